id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register; sits directly downstream of the condition-check logic in the decode stage.
- Captures decoded operands and control signals each cycle and annuls the control side when the instruction's condition fails or a hazard bubble is required.
- Supports branch flush and whole-pipeline freeze for memory stalls.
- Also snapshots the status register {z,c,n,v} seen at decode for use by EX.

---
 rtl/id_ex_stage_reg.sv | 115 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control each cycle,
// annulling the control side on a failed condition or hazard bubble.
module id_ex_stage_reg #(
   parameter int WORD_W  = 32,
   parameter int SHIFT_W = 12,
   parameter int IMM24_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               freeze,
   input  logic               hazard,
   input  logic               cond_ok,
   input  logic [WORD_W-1:0]  pc_in,
   input  logic               wb_en_in,
   input  logic               mem_r_en_in,
   input  logic               mem_w_en_in,
   input  logic               b_in,
   input  logic               s_in,
   input  logic [3:0]         exe_cmd_in,
   input  logic               imm_in,
   input  logic [WORD_W-1:0]  val_rn_in,
   input  logic [WORD_W-1:0]  val_rm_in,
   input  logic [SHIFT_W-1:0] shift_operand_in,
   input  logic [IMM24_W-1:0] signed_imm_24_in,
   input  logic [3:0]         dest_in,
   input  logic [3:0]         src1_in,
   input  logic [3:0]         src2_in,
   input  logic [3:0]         sr_in,
   output logic [WORD_W-1:0]  pc,
   output logic               wb_en,
   output logic               mem_r_en,
   output logic               mem_w_en,
   output logic               b,
   output logic               s,
   output logic [3:0]         exe_cmd,
   output logic               imm,
   output logic [WORD_W-1:0]  val_rn,
   output logic [WORD_W-1:0]  val_rm,
   output logic [SHIFT_W-1:0] shift_operand,
   output logic [IMM24_W-1:0] signed_imm_24,
   output logic [3:0]         dest,
   output logic [3:0]         src1,
   output logic [3:0]         src2,
   output logic [3:0]         sr,
   output logic               valid
);

   logic w_kill;

   assign w_kill = hazard | ~cond_ok;

   // Freeze holds everything; a killed instruction keeps its data fields so the
   // forwarding unit and debug still see consistent indices, only side effects drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= '0;
         wb_en         <= 1'b0;
         mem_r_en      <= 1'b0;
         mem_w_en      <= 1'b0;
         b             <= 1'b0;
         s             <= 1'b0;
         exe_cmd       <= '0;
         imm           <= 1'b0;
         val_rn        <= '0;
         val_rm        <= '0;
         shift_operand <= '0;
         signed_imm_24 <= '0;
         dest          <= '0;
         src1          <= '0;
         src2          <= '0;
         sr            <= '0;
         valid         <= 1'b0;
      end else if (!freeze) begin
         if (flush) begin
            pc            <= '0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            exe_cmd       <= '0;
            imm           <= 1'b0;
            val_rn        <= '0;
            val_rm        <= '0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
            sr            <= '0;
            valid         <= 1'b0;
         end else begin
            pc            <= pc_in;
            wb_en         <= wb_en_in & ~w_kill;
            mem_r_en      <= mem_r_en_in & ~w_kill;
            mem_w_en      <= mem_w_en_in & ~w_kill;
            b             <= b_in & ~w_kill;
            s             <= s_in & ~w_kill;
            exe_cmd       <= exe_cmd_in;
            imm           <= imm_in;
            val_rn        <= val_rn_in;
            val_rm        <= val_rm_in;
            shift_operand <= shift_operand_in;
            signed_imm_24 <= signed_imm_24_in;
            dest          <= dest_in;
            src1          <= src1_in;
            src2          <= src2_in;
            sr            <= sr_in;
            valid         <= ~w_kill;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg: reset, load, kill,
// freeze/flush priority and reset-during-freeze.
module tb_id_ex_stage_reg;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush, freeze, hazard, condOk;
   logic [31:0] pcIn, valRnIn, valRmIn;
   logic        wbEnIn, memREnIn, memWEnIn, bIn, sIn, immIn;
   logic [3:0]  exeCmdIn, destIn, src1In, src2In, srIn;
   logic [11:0] shiftOperandIn;
   logic [23:0] signedImm24In;

   logic [31:0] pc, valRn, valRm;
   logic        wbEn, memREn, memWEn, b, s, imm, valid;
   logic [3:0]  exeCmd, dest, src1, src2, sr;
   logic [11:0] shiftOperand;
   logic [23:0] signedImm24;

   logic [158:0] allOut;
   logic [157:0] allIn;
   logic [157:0] killIn;
   logic [158:0] snapshot;

   int checks   = 0;
   int failures = 0;

   assign allOut = {pc, wbEn, memREn, memWEn, b, s, exeCmd, imm, valRn, valRm,
                    shiftOperand, signedImm24, dest, src1, src2, sr, valid};
   assign allIn  = {pcIn, wbEnIn, memREnIn, memWEnIn, bIn, sIn, exeCmdIn, immIn, valRnIn,
                    valRmIn, shiftOperandIn, signedImm24In, destIn, src1In, src2In, srIn};
   assign killIn = {pcIn, 5'b0, exeCmdIn, immIn, valRnIn, valRmIn,
                    shiftOperandIn, signedImm24In, destIn, src1In, src2In, srIn};

   always #5 clock = ~clock;

   id_ex_stage_reg dut (
      .clk(clock), .rst(reset), .flush(flush), .freeze(freeze), .hazard(hazard),
      .cond_ok(condOk), .pc_in(pcIn), .wb_en_in(wbEnIn), .mem_r_en_in(memREnIn),
      .mem_w_en_in(memWEnIn), .b_in(bIn), .s_in(sIn), .exe_cmd_in(exeCmdIn),
      .imm_in(immIn), .val_rn_in(valRnIn), .val_rm_in(valRmIn),
      .shift_operand_in(shiftOperandIn), .signed_imm_24_in(signedImm24In),
      .dest_in(destIn), .src1_in(src1In), .src2_in(src2In), .sr_in(srIn),
      .pc(pc), .wb_en(wbEn), .mem_r_en(memREn), .mem_w_en(memWEn), .b(b), .s(s),
      .exe_cmd(exeCmd), .imm(imm), .val_rn(valRn), .val_rm(valRm),
      .shift_operand(shiftOperand), .signed_imm_24(signedImm24), .dest(dest),
      .src1(src1), .src2(src2), .sr(sr), .valid(valid)
   );

   // Fills every data/control input from one byte so patterns are easy to tell apart.
   task automatic applyStimulus(input logic [7:0] f);
      pcIn           = {4{f}};
      wbEnIn         = f[0];
      memREnIn       = f[1];
      memWEnIn       = f[2];
      bIn            = f[3];
      sIn            = f[4];
      exeCmdIn       = f[3:0];
      immIn          = f[5];
      valRnIn        = {4{f}};
      valRmIn        = ~{4{f}};
      shiftOperandIn = {f[3:0], f};
      signedImm24In  = {3{f}};
      destIn         = f[7:4];
      src1In         = f[3:0];
      src2In         = f[7:4] ^ f[3:0];
      srIn           = f[7:4];
   endtask

   task automatic setControl(input logic fl, input logic fr, input logic hz, input logic ok);
      flush  = fl;
      freeze = fr;
      hazard = hz;
      condOk = ok;
   endtask

   task automatic test_reset;
      @(negedge clock);
      applyStimulus(8'hA5);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL reset_async: got %h want 0", allOut);
      end
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(8'h3C);
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== {allIn, 1'b1}) begin
         failures++;
         $display("FAIL reset_release_load: got %h want %h", allOut, {allIn, 1'b1});
      end
   endtask

   task automatic test_normal_load;
      @(negedge clock);
      applyStimulus(8'h00);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      pcIn = 32'h10; wbEnIn = 1'b1; exeCmdIn = 4'b0010; valRnIn = 32'd5; srIn = 4'b1000;
      @(posedge clock);
      #1;
      checks++;
      if ({pc, wbEn, exeCmd, valRn, sr, valid} !== {32'h10, 1'b1, 4'd2, 32'd5, 4'b1000, 1'b1}) begin
         failures++;
         $display("FAIL normal_load: got pc=%h wb=%b cmd=%h rn=%h sr=%b v=%b want pc=10 wb=1 cmd=2 rn=5 sr=1000 v=1",
                  pc, wbEn, exeCmd, valRn, sr, valid);
      end
      checks++;
      if (allOut !== {allIn, 1'b1}) begin
         failures++;
         $display("FAIL normal_load_all: got %h want %h", allOut, {allIn, 1'b1});
      end
   endtask

   task automatic test_cond_fail;
      @(negedge clock);
      condOk = 1'b0; memWEnIn = 1'b1; sIn = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if ({wbEn, memWEn, s, valid, pc, valRn} !== {4'b0000, 32'h10, 32'd5}) begin
         failures++;
         $display("FAIL cond_fail: got wb=%b mw=%b s=%b v=%b pc=%h rn=%h want 0 0 0 0 pc=10 rn=5",
                  wbEn, memWEn, s, valid, pc, valRn);
      end
      checks++;
      if (allOut !== {killIn, 1'b0}) begin
         failures++;
         $display("FAIL cond_fail_all: got %h want %h", allOut, {killIn, 1'b0});
      end
   endtask

   task automatic test_hazard;
      @(negedge clock);
      applyStimulus(8'h5A);
      setControl(1'b0, 1'b0, 1'b1, 1'b1);
      bIn = 1'b1; destIn = 4'hB;
      @(posedge clock);
      #1;
      checks++;
      if ({b, valid, dest} !== {1'b0, 1'b0, 4'hB}) begin
         failures++;
         $display("FAIL hazard_bubble: got b=%b v=%b dest=%h want b=0 v=0 dest=b", b, valid, dest);
      end
      checks++;
      if (allOut !== {killIn, 1'b0}) begin
         failures++;
         $display("FAIL hazard_all: got %h want %h", allOut, {killIn, 1'b0});
      end
   endtask

   task automatic test_freeze_flush;
      logic [7:0] pats [3] = '{8'h11, 8'hEE, 8'h77};
      @(negedge clock);
      applyStimulus(8'hC3);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      snapshot = {allIn, 1'b1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         applyStimulus(pats[i]);
         setControl(1'b1, 1'b1, i[0], i[1]);
         @(posedge clock);
         #1;
         checks++;
         if (allOut !== snapshot) begin
            failures++;
            $display("FAIL freeze_hold_%0d: got %h want %h", i, allOut, snapshot);
         end
      end
      @(negedge clock);
      freeze = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL unfreeze_flush: got %h want 0", allOut);
      end
   endtask

   task automatic test_flush_over_hazard;
      @(negedge clock);
      applyStimulus(8'hFF);
      setControl(1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL flush_over_hazard: got %h want 0", allOut);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clock);
      applyStimulus(8'h96);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== {allIn, 1'b1}) begin
         failures++;
         $display("FAIL after_flush_load: got %h want %h", allOut, {allIn, 1'b1});
      end
      @(negedge clock);
      applyStimulus(8'h69);
      setControl(1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== {killIn, 1'b0}) begin
         failures++;
         $display("FAIL load_then_hazard: got %h want %h", allOut, {killIn, 1'b0});
      end
   endtask

   task automatic test_reset_mid_freeze;
      @(negedge clock);
      applyStimulus(8'h4D);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clock);
      @(negedge clock);
      freeze = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL reset_in_freeze: got %h want 0", allOut);
      end
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(8'hB2);
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL frozen_after_reset: got %h want 0", allOut);
      end
      @(negedge clock);
      freeze = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (allOut !== {allIn, 1'b1}) begin
         failures++;
         $display("FAIL resume_after_freeze: got %h want %h", allOut, {allIn, 1'b1});
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(8'h00);
      setControl(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("FAIL power_on_reset: got %h want 0", allOut);
      end
      @(negedge clock);
      reset = 1'b0;
      test_reset;
      test_normal_load;
      test_cond_fail;
      test_hazard;
      test_freeze_flush;
      test_flush_over_hazard;
      test_back_to_back;
      test_reset_mid_freeze;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
